phys_reg_manager: RTL and testbench

Unified physical-register bookkeeping for the R10K rename stage: one block holds the free list, the complete (ready) list and a set of branch checkpoints of the free list. It grants up to `ALLOC_W` free registers per cycle to dispatch, marks registers ready from the CDB, and frees T_old registers from retire. On a branch mispredict it restores the free list from the checkpoint and squashes that checkpoint and every younger one. It replaces the separate free/complete list blocks and the free-list copy in the branch stack.

---
 rtl/sys_defs.sv | 27 ++
 rtl/multi_psel.sv | 33 +++
 rtl/phys_reg_manager.sv | 129 ++++++++++++
 tb/tb_phys_reg_manager.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared rename-stage sizes and index types
//
// Purpose: physical-register and checkpoint sizing shared by the rename blocks.
// Ports: none (package).
package sys_defs;

  localparam int PHYS_REGS  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int ALLOC_W    = 3;
  localparam int CMPL_W     = 3;
  localparam int RETIRE_W   = 3;
  localparam int CKPT_DEPTH = 4;

  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int CKPT_W = $clog2(CKPT_DEPTH);
  localparam int ACNT_W = $clog2(ALLOC_W + 1);
  localparam int FCNT_W = $clog2(PHYS_REGS + 1);

  typedef logic [PREG_W-1:0] PHYS_REG_IDX;
  typedef logic [CKPT_W-1:0] CKPT_TAG;

  // Architectural mapping occupies the low registers out of reset.
  localparam logic [PHYS_REGS-1:0] FREE_RESET =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
  localparam logic [PHYS_REGS-1:0] COMPLETE_RESET = ~FREE_RESET;

endpackage

// File: rtl/multi_psel.sv
// rtl/multi_psel.sv - pick the SEL lowest set bits of a request vector
//
// Purpose: priority selector returning the indices of the lowest set bits.
// Ports:
//   req   in  WIDTH            - request vector
//   idx   out SEL x clog2(W)   - lane i = i-th lowest set bit (0 when unused)
//   count out clog2(SEL+1)     - number of lanes filled, min(popcount, SEL)
module multi_psel #(
  parameter int WIDTH = 64,
  parameter int SEL   = 3
) (
  input  logic [WIDTH-1:0]                      req,
  output logic [SEL-1:0][$clog2(WIDTH)-1:0]     idx,
  output logic [$clog2(SEL+1)-1:0]              count
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(SEL + 1);

  always_comb begin
    int c;
    c = 0;
    idx = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (req[b] && c < SEL) begin
        idx[c] = IW'(b);
        c = c + 1;
      end
    end
    count = CW'(c);
  end

endmodule

// File: rtl/phys_reg_manager.sv
// rtl/phys_reg_manager.sv - free list, ready list and branch checkpoints
//
// Purpose: physical-register bookkeeping for rename: grants free registers,
// tracks completion, frees T_old on retire, snapshots/restores the free list.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   alloc_count/ok/idx/avail          - dispatch allocation request and grant
//   cmpl_valid/idx                    - CDB completions (set ready bit)
//   retire_valid/idx                  - retired T_old registers (set free bit)
//   ckpt_take/tag/full                - branch checkpoint allocation
//   resolve_valid/tag/mispredict      - branch resolution
//   free_list, complete_list          - current state bitvectors
//   free_count                        - popcount of free_list
module phys_reg_manager
  import sys_defs::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ACNT_W-1:0]          alloc_count,
  output logic                       alloc_ok,
  output PHYS_REG_IDX [ALLOC_W-1:0]  alloc_idx,
  output logic [ACNT_W-1:0]          alloc_avail,
  input  logic [CMPL_W-1:0]          cmpl_valid,
  input  PHYS_REG_IDX [CMPL_W-1:0]   cmpl_idx,
  input  logic [RETIRE_W-1:0]        retire_valid,
  input  PHYS_REG_IDX [RETIRE_W-1:0] retire_idx,
  input  logic                       ckpt_take,
  output CKPT_TAG                    ckpt_tag,
  output logic                       ckpt_full,
  input  logic                       resolve_valid,
  input  CKPT_TAG                    resolve_tag,
  input  logic                       resolve_mispredict,
  output logic [PHYS_REGS-1:0]       free_list,
  output logic [PHYS_REGS-1:0]       complete_list,
  output logic [FCNT_W-1:0]          free_count
);

  logic [PHYS_REGS-1:0]  ckpt_free [CKPT_DEPTH];
  logic [CKPT_DEPTH-1:0] ckpt_dep  [CKPT_DEPTH];
  logic [CKPT_DEPTH-1:0] ckpt_valid;

  logic [PHYS_REGS-1:0]  alloc_mask, retire_mask, cmpl_mask;
  logic [PHYS_REGS-1:0]  free_live_next, free_next;
  logic [CKPT_DEPTH-1:0] kill;
  logic                  mispredict, take, slot_found;

  multi_psel #(.WIDTH(PHYS_REGS), .SEL(ALLOC_W)) u_alloc_sel (
    .req   (free_list),
    .idx   (alloc_idx),
    .count (alloc_avail)
  );

  multi_psel #(.WIDTH(CKPT_DEPTH), .SEL(1)) u_slot_sel (
    .req   (~ckpt_valid),
    .idx   (ckpt_tag),
    .count (slot_found)
  );

  assign mispredict = resolve_valid && resolve_mispredict;
  assign ckpt_full  = !slot_found;
  assign alloc_ok   = (alloc_count <= alloc_avail) && !mispredict;
  assign take       = ckpt_take && !ckpt_full && !mispredict;

  always_comb begin
    alloc_mask  = '0;
    retire_mask = '0;
    cmpl_mask   = '0;
    for (int i = 0; i < ALLOC_W; i++)
      if (alloc_ok && ACNT_W'(i) < alloc_count) alloc_mask[alloc_idx[i]] = 1'b1;
    for (int i = 0; i < RETIRE_W; i++)
      if (retire_valid[i]) retire_mask[retire_idx[i]] = 1'b1;
    for (int i = 0; i < CMPL_W; i++)
      if (cmpl_valid[i]) cmpl_mask[cmpl_idx[i]] = 1'b1;
    // x0 is permanently allocated and ready
    retire_mask[0] = 1'b0;
    cmpl_mask[0]   = 1'b0;
  end

  // Allocated and retiring registers are disjoint for legal input, so the
  // order of clear and set does not matter.
  assign free_live_next = (free_list & ~alloc_mask) | retire_mask;
  assign free_next = mispredict ? (ckpt_free[resolve_tag] | retire_mask)
                                : free_live_next;

  // Slots leaving this cycle: the resolved tag, plus on a mispredict every
  // younger slot that recorded it as a dependency.
  always_comb begin
    kill = '0;
    if (resolve_valid) begin
      kill[resolve_tag] = 1'b1;
      if (resolve_mispredict)
        for (int s = 0; s < CKPT_DEPTH; s++)
          if (ckpt_valid[s] && ckpt_dep[s][resolve_tag]) kill[s] = 1'b1;
    end
  end

  always_comb begin
    free_count = '0;
    for (int b = 0; b < PHYS_REGS; b++)
      free_count = free_count + FCNT_W'(free_list[b]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_list     <= FREE_RESET;
      complete_list <= COMPLETE_RESET;
      ckpt_valid    <= '0;
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        ckpt_free[s] <= '0;
        ckpt_dep[s]  <= '0;
      end
    end else begin
      free_list     <= free_next;
      complete_list <= (complete_list & ~alloc_mask) | cmpl_mask;
      ckpt_valid    <= (ckpt_valid & ~kill) |
                       (take ? (CKPT_DEPTH'(1) << ckpt_tag) : '0);
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        if (take && ckpt_tag == CKPT_W'(s)) begin
          ckpt_free[s] <= free_live_next;
          ckpt_dep[s]  <= ckpt_valid & ~kill;
        end else begin
          if (ckpt_valid[s]) ckpt_free[s] <= ckpt_free[s] | retire_mask;
          ckpt_dep[s] <= ckpt_dep[s] & ~kill;
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_manager.sv
// tb/tb_phys_reg_manager.sv - self-checking bench for phys_reg_manager
module tb_phys_reg_manager;
  import sys_defs::*;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [ACNT_W-1:0]          alloc_count;
  logic                       alloc_ok;
  PHYS_REG_IDX [ALLOC_W-1:0]  alloc_idx;
  logic [ACNT_W-1:0]          alloc_avail;
  logic [CMPL_W-1:0]          cmpl_valid;
  PHYS_REG_IDX [CMPL_W-1:0]   cmpl_idx;
  logic [RETIRE_W-1:0]        retire_valid;
  PHYS_REG_IDX [RETIRE_W-1:0] retire_idx;
  logic                       ckpt_take;
  CKPT_TAG                    ckpt_tag;
  logic                       ckpt_full;
  logic                       resolve_valid;
  CKPT_TAG                    resolve_tag;
  logic                       resolve_mispredict;
  logic [PHYS_REGS-1:0]       free_list;
  logic [PHYS_REGS-1:0]       complete_list;
  logic [FCNT_W-1:0]          free_count;

  phys_reg_manager dut (
    .clock(clock), .reset(reset),
    .alloc_count(alloc_count), .alloc_ok(alloc_ok), .alloc_idx(alloc_idx),
    .alloc_avail(alloc_avail),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .retire_valid(retire_valid), .retire_idx(retire_idx),
    .ckpt_take(ckpt_take), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .free_list(free_list), .complete_list(complete_list), .free_count(free_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    int rv;
    int ridx;
    int ok;
    int avail;
    int idx0;
    int idx1;
    int fc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_count        = '0;
    cmpl_valid         = '0;
    cmpl_idx           = '0;
    retire_valid       = '0;
    retire_idx         = '0;
    ckpt_take          = 1'b0;
    resolve_valid      = 1'b0;
    resolve_tag        = '0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic take_ckpt(input int cnt, input int exp_tag, input string name);
    clear_inputs();
    ckpt_take   = 1'b1;
    alloc_count = ACNT_W'(cnt);
    #1;
    chk(name, 64'(ckpt_tag), 64'(exp_tag));
    tick();
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("rst_free_count", 64'(free_count), 64'd32);
    chk("rst_alloc_avail", 64'(alloc_avail), 64'd3);
    chk("rst_idx0", 64'(alloc_idx[0]), 64'd32);
    chk("rst_idx1", 64'(alloc_idx[1]), 64'd33);
    chk("rst_idx2", 64'(alloc_idx[2]), 64'd34);
    chk("rst_complete", complete_list, 64'h0000_0000_FFFF_FFFF);
    chk("rst_free", free_list, 64'hFFFF_FFFF_0000_0000);
    chk("rst_ckpt_tag", 64'(ckpt_tag), 64'd0);
    chk("rst_ckpt_full", 64'(ckpt_full), 64'd0);
    reset = 1'b0;

    // ---------------- allocation table ----------------
    for (int k = 0; k < 10; k++)
      vecs[k] = '{cnt:3, rv:0, ridx:0, ok:1, avail:3, idx0:32+3*k, idx1:33+3*k, fc:32-3*k};
    vecs[10] = '{cnt:3, rv:0, ridx:0, ok:0, avail:2, idx0:62, idx1:63, fc:2};
    vecs[11] = '{cnt:0, rv:1, ridx:5, ok:1, avail:2, idx0:62, idx1:63, fc:2};
    vecs[12] = '{cnt:0, rv:0, ridx:0, ok:1, avail:3, idx0:5,  idx1:62, fc:3};

    for (int i = 0; i < 13; i++) begin
      clear_inputs();
      alloc_count     = ACNT_W'(vecs[i].cnt);
      retire_valid[0] = vecs[i].rv[0];
      retire_idx[0]   = PREG_W'(vecs[i].ridx);
      #1;
      chk($sformatf("v%0d_ok", i), 64'(alloc_ok), 64'(vecs[i].ok));
      chk($sformatf("v%0d_avail", i), 64'(alloc_avail), 64'(vecs[i].avail));
      chk($sformatf("v%0d_idx0", i), 64'(alloc_idx[0]), 64'(vecs[i].idx0));
      chk($sformatf("v%0d_idx1", i), 64'(alloc_idx[1]), 64'(vecs[i].idx1));
      chk($sformatf("v%0d_fc", i), 64'(free_count), 64'(vecs[i].fc));
      tick();
    end

    // ---------------- completion / reallocation ----------------
    clear_inputs();
    cmpl_valid  = 3'b011;
    cmpl_idx[0] = 6'd32;
    cmpl_idx[1] = 6'd40;
    tick();
    chk("cmpl_32_set", 64'(complete_list[32]), 64'd1);
    chk("cmpl_40_set", 64'(complete_list[40]), 64'd1);
    clear_inputs();
    retire_valid  = 3'b100;
    retire_idx[2] = 6'd32;
    tick();
    clear_inputs();
    alloc_count = 2'd2;
    #1;
    chk("realloc_idx0", 64'(alloc_idx[0]), 64'd5);
    chk("realloc_idx1", 64'(alloc_idx[1]), 64'd32);
    chk("realloc_ok", 64'(alloc_ok), 64'd1);
    tick();
    chk("cmpl_32_clr", 64'(complete_list[32]), 64'd0);
    chk("cmpl_40_keep", 64'(complete_list[40]), 64'd1);
    chk("cmpl_5_clr", 64'(complete_list[5]), 64'd0);
    chk("realloc_fc", 64'(free_count), 64'd2);

    // ---------------- reset overrides same-cycle inputs ----------------
    clear_inputs();
    reset           = 1'b1;
    alloc_count     = 2'd3;
    retire_valid[0] = 1'b1;
    retire_idx[0]   = 6'd10;
    cmpl_valid[0]   = 1'b1;
    cmpl_idx[0]     = 6'd40;
    ckpt_take       = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("mid_rst_free", free_list, 64'hFFFF_FFFF_0000_0000);
    chk("mid_rst_cmpl", complete_list, 64'h0000_0000_FFFF_FFFF);
    chk("mid_rst_tag", 64'(ckpt_tag), 64'd0);

    // ---------------- checkpoints A,B,C then mispredict A ----------------
    take_ckpt(1, 0, "ckA_tag");
    take_ckpt(1, 1, "ckB_tag");
    take_ckpt(1, 2, "ckC_tag");
    clear_inputs();
    alloc_count = 2'd3;
    tick();
    clear_inputs();
    resolve_valid      = 1'b1;
    resolve_tag        = 2'd0;
    resolve_mispredict = 1'b1;
    retire_valid[1]    = 1'b1;
    retire_idx[1]      = 6'd7;
    alloc_count        = 2'd3;
    ckpt_take          = 1'b1;
    #1;
    chk("mpA_alloc_ok", 64'(alloc_ok), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("mpA_free", free_list, 64'hFFFF_FFFE_0000_0080);
    chk("mpA_fc", 64'(free_count), 64'd32);
    chk("mpA_tag", 64'(ckpt_tag), 64'd0);

    // ---------------- resolve B + take D, mispredict C ----------------
    clear_inputs();
    alloc_count = 2'd1;
    #1;
    chk("t1_idx0", 64'(alloc_idx[0]), 64'd7);
    take_ckpt(1, 0, "t1_tag");
    take_ckpt(1, 1, "t2_tag");
    take_ckpt(1, 2, "t3_tag");
    clear_inputs();
    resolve_valid = 1'b1;
    resolve_tag   = 2'd1;
    ckpt_take     = 1'b1;
    alloc_count   = 2'd1;
    #1;
    chk("t4_tag", 64'(ckpt_tag), 64'd3);
    tick();
    clear_inputs();
    #1;
    chk("t5_tag_reuse", 64'(ckpt_tag), 64'd1);
    chk("t5_fc", 64'(free_count), 64'd28);
    resolve_valid      = 1'b1;
    resolve_tag        = 2'd2;
    resolve_mispredict = 1'b1;
    alloc_count        = 2'd1;
    #1;
    chk("t5_alloc_ok", 64'(alloc_ok), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("t6_free", free_list, 64'hFFFF_FFF8_0000_0000);
    chk("t6_fc", 64'(free_count), 64'd29);
    take_ckpt(1, 1, "t6_tag");
    take_ckpt(0, 2, "t7_tag");
    take_ckpt(0, 3, "t8_tag");

    // ---------------- full: take ignored ----------------
    clear_inputs();
    ckpt_take   = 1'b1;
    alloc_count = 2'd1;
    #1;
    chk("t9_full", 64'(ckpt_full), 64'd1);
    chk("t9_idx0", 64'(alloc_idx[0]), 64'd36);
    tick();
    clear_inputs();
    #1;
    chk("t10_full", 64'(ckpt_full), 64'd1);
    resolve_valid = 1'b1;
    resolve_tag   = 2'd1;
    tick();
    clear_inputs();
    #1;
    chk("t11_full", 64'(ckpt_full), 64'd0);
    chk("t11_tag", 64'(ckpt_tag), 64'd1);
    resolve_valid      = 1'b1;
    resolve_tag        = 2'd0;
    resolve_mispredict = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("t12_free", free_list, 64'hFFFF_FFFE_0000_0000);
    chk("t12_fc", 64'(free_count), 64'd31);
    chk("t12_tag", 64'(ckpt_tag), 64'd0);
    chk("t12_full", 64'(ckpt_full), 64'd0);

    // ---------------- index 0 ignored ----------------
    retire_valid[0] = 1'b1;
    retire_idx[0]   = 6'd0;
    cmpl_valid[2]   = 1'b1;
    cmpl_idx[2]     = 6'd0;
    tick();
    clear_inputs();
    #1;
    chk("x0_free", free_list, 64'hFFFF_FFFE_0000_0000);
    chk("x0_cmpl", 64'(complete_list[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
